ram_load_store_unit: RTL and testbench
======================================

// Module: ram_load_store_unit
// PURPOSE
//  Initiator for one port of the byte-enabled dual-port RAM (1-cycle registered read latency).
//  Converts RISC-V style byte-addressed load/store requests (byte/half/word, signed/unsigned)
//  into word-addressed RAM accesses with byte enables. Handles lane alignment and load extension.
//  Sits between the core's memory stage and RAM port A or B. At most one request is outstanding.
// PARAMETERS
//  RAM_WIDTH  32   RAM word width in bits; multiple of 8; NB = RAM_WIDTH/8 bytes per word
//  RAM_DEPTH  512  RAM depth in words; AW = $clog2(RAM_DEPTH), OW = $clog2(NB)
// PORTS
//  clk           in   1          clock; everything sampled on rising edge
//  reset         in   1          asynchronous, active-high reset
//  req_valid     in   1          request valid
//  req_ready     out  1          request ready; accept = req_valid & req_ready
//  req_addr      in   AW+OW      byte address
//  req_we        in   1          1 = store, 0 = load
//  req_size      in   2          log2(bytes): 0 = byte, 1 = half, 2 = word, 3 = dword (legal only if 8 <= NB)
//  req_unsigned  in   1          loads only: 1 = zero-extend, 0 = sign-extend
//  req_wdata     in   RAM_WIDTH  store data, right-justified
//  resp_valid    out  1          response valid; held until resp_ready
//  resp_ready    in   1          response accept
//  resp_rdata    out  RAM_WIDTH  load data, extended; 0 for stores and errors
//  resp_err      out  1          illegal size, or misaligned access (see CONFIGURATION)
//  ram_addr      out  AW         RAM word address
//  ram_din       out  RAM_WIDTH  RAM write data, lane-positioned
//  ram_we        out  1          RAM write enable
//  ram_byte_en   out  NB         RAM byte enables
//  ram_dout      in   RAM_WIDTH  RAM read data, valid the cycle after the address is driven
// BEHAVIOUR
//  Reset: all outputs 0, except req_ready = 1; FSM = IDLE. Reset is async and may hit mid-op:
//    FSM returns to IDLE and ram_we drops at once. A split store may be left half-written; this is accepted.
//  FSM IDLE -> ISSUE0 -> [ISSUE1] -> [CAPTURE] -> RESP -> IDLE. req_ready = 1 only in IDLE.
//  IDLE: on accept, register the request; off = addr[OW-1:0], wa = addr[AW+OW-1:OW].
//    Illegal size, or misaligned with the split feature out -> RESP with err = 1; no RAM access.
//  Access: alignment is legal when off % 2^size == 0; split = off + 2^size > NB.
//  ISSUE0: ram_addr = wa; be = ((1 << 2^size) - 1) << off, over a 2*NB window.
//    din = wdata << 8*off, over a 2*RAM_WIDTH window. The beat drives window bits [NB-1:0] / [W-1:0].
//    Stores: ram_we = 1 in ISSUE states only.
//  ISSUE1 (split only): ram_addr = wa + 1 mod RAM_DEPTH, so DEPTH-1 wraps to 0.
//    Drives the upper window half. For loads, captures ram_dout (beat 0) into lo_q.
//  CAPTURE (loads only): assemble {ram_dout, lo_q}, or {0, ram_dout} unsplit.
//    Then >> 8*off, truncate to 2^size bytes, sign/zero-extend, and register into resp_rdata.
//  RESP: resp_valid = 1, stable until resp_ready; resp_valid & resp_ready -> IDLE. Earliest new accept is the next cycle.
//  Latency (accept at T -> resp_valid): store T+2; load T+3; split store T+3; split load T+4; error T+1.
//  Outside ISSUE states: ram_we = 0, ram_byte_en = 0; ram_addr and ram_din hold their last values.
// CONFIGURATION
//  LSU_MISALIGN_SPLIT_EN defined: misaligned accesses complete. Those that cross a word go out as
//    two beats (wa, wa+1); those within one word take a single beat.
//  Not defined: any misaligned access returns resp_err = 1 and resp_rdata = 0, with no RAM traffic;
//    ISSUE1 and lo_q are not built.
// STRUCTURE
//  Package lsu_pkg: lsu_size_e (SZ_B/SZ_H/SZ_W/SZ_D), lsu_state_e (IDLE/ISSUE0/ISSUE1/CAPTURE/RESP),
//    function lsu_byte_en(size, off) returning the 2*NB-bit enable window.
//  Sub-module lsu_rdata_align: combinational; window + off + size + unsigned -> extended load data.
// TESTING
//  SW 0xDEADBEEF @0x10 then LW @0x10 -> RAM word 4 gets be=4'hF; resp_rdata=0xDEADBEEF at T+3.
//  SB 0x80 @0x13, LB @0x13 -> be=4'h8, din[31:24]=0x80; LB gives 0xFFFFFF80, LBU gives 0x00000080.
//  SH 0xA5C3 @0x0E -> single beat, wa=3, be=4'hC; LH @0x0E gives 0xFFFFA5C3.
//  SPLIT_EN: SW 0x11223344 @0x7FF (DEPTH 512) -> word 511 be=8, word 0 be=7; LW returns same at T+4.
//  No SPLIT_EN: LW @0x5 -> resp_err=1 at T+1, ram_we never set; size=3 with W=32 -> err.
//  Hold resp_ready=0 for 5 cycles -> resp stable, req_ready=0; reset asserted in ISSUE0 -> ram_we drops at once, req_ready=1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the RAM load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} lsu_size_e;

  typedef enum logic [2:0] {IDLE, ISSUE0, ISSUE1, CAPTURE, RESP} lsu_state_e;

  // Sized for RAM words of up to 16 bytes (two-word enable window).
  localparam int unsigned LSU_OFF_W  = 4;
  localparam int unsigned LSU_BE_WIN = 32;

  function automatic logic [LSU_BE_WIN-1:0] lsu_byte_en(input lsu_size_e size,
                                                        input logic [LSU_OFF_W-1:0] off);
    logic [LSU_BE_WIN-1:0] ones;
    ones = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < (1 << size)) ones[i] = 1'b1;
    end
    return ones << off;
  endfunction

endpackage

// File: rtl/lsu_rdata_align.sv
// Load data alignment: shifts the captured window down to the access offset, then extends.
module lsu_rdata_align
  import lsu_pkg::*;
#(
  parameter int unsigned RAM_WIDTH = 32,
  localparam int unsigned NB = RAM_WIDTH / 8,
  localparam int unsigned OW = $clog2(NB)
) (
  input  logic [2*RAM_WIDTH-1:0] win,
  input  logic [OW-1:0]          off,
  input  lsu_size_e              size,
  input  logic                   is_unsigned,
  output logic [RAM_WIDTH-1:0]   rdata
);

  logic [RAM_WIDTH-1:0] lo;
  int unsigned          nbytes;
  logic                 sign;

  always_comb begin
    lo     = RAM_WIDTH'(win >> {off, 3'b000});
    nbytes = 32'd1 << size;
    sign   = 1'b0;
    for (int i = 0; i < int'(NB); i++) begin
      if (32'(i) == nbytes - 32'd1) sign = lo[8*i+7];
    end
    sign  = sign & ~is_unsigned;
    rdata = '0;
    for (int i = 0; i < int'(NB); i++) begin
      rdata[8*i +: 8] = (32'(i) < nbytes) ? lo[8*i +: 8] : {8{sign}};
    end
  end

endmodule

// File: rtl/ram_load_store_unit.sv
// Byte-addressed load/store initiator for one port of a byte-enabled RAM (1-cycle read).
// Optional feature macro: LSU_MISALIGN_SPLIT_EN (misaligned accesses complete, split across words).
module ram_load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned RAM_WIDTH = 32,
  parameter int unsigned RAM_DEPTH = 512,
  localparam int unsigned NB = RAM_WIDTH / 8,
  localparam int unsigned AW = $clog2(RAM_DEPTH),
  localparam int unsigned OW = $clog2(NB)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [AW+OW-1:0]     req_addr,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [RAM_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [RAM_WIDTH-1:0] resp_rdata,
  output logic                 resp_err,
  output logic [AW-1:0]        ram_addr,
  output logic [RAM_WIDTH-1:0] ram_din,
  output logic                 ram_we,
  output logic [NB-1:0]        ram_byte_en,
  input  logic [RAM_WIDTH-1:0] ram_dout
);

  lsu_state_e state;

  logic            we_q;
  lsu_size_e       size_q;
  logic            uns_q;
  logic [OW-1:0]   off_q;
  logic [AW-1:0]   wa_q;

  logic [OW-1:0]          req_off;
  logic [AW-1:0]          req_wa;
  int unsigned            req_nbytes;
  logic                   req_illegal;
  logic                   req_misalign;
  logic                   req_err;
  logic [LSU_BE_WIN-1:0]  be_full;
  logic [2*NB-1:0]        req_be_win;
  logic [2*RAM_WIDTH-1:0] req_din_win;
  logic [2*RAM_WIDTH-1:0] cap_win;
  logic [RAM_WIDTH-1:0]   align_rdata;
  logic                   unused_win;

  assign req_off = req_addr[OW-1:0];
  assign req_wa  = req_addr[AW+OW-1:OW];

`ifdef LSU_MISALIGN_SPLIT_EN
  logic                 req_split;
  logic                 split_q;
  logic [NB-1:0]        be_hi_q;
  logic [RAM_WIDTH-1:0] din_hi_q;
  logic [RAM_WIDTH-1:0] lo_q;
  logic [AW-1:0]        wa_next;

  assign wa_next    = (32'(wa_q) == RAM_DEPTH - 1) ? '0 : wa_q + 1'b1;
  assign cap_win    = split_q ? {ram_dout, lo_q} : {{RAM_WIDTH{1'b0}}, ram_dout};
  assign unused_win = ^{be_full[LSU_BE_WIN-1:2*NB], req_misalign};
`else
  assign cap_win    = {{RAM_WIDTH{1'b0}}, ram_dout};
  assign unused_win = ^{be_full[LSU_BE_WIN-1:NB], req_din_win[2*RAM_WIDTH-1:RAM_WIDTH]};
`endif

  always_comb begin
    req_nbytes   = 32'd1 << req_size;
    req_illegal  = req_nbytes > NB;
    req_misalign = (32'(req_off) & (req_nbytes - 32'd1)) != 32'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
    req_split    = (32'(req_off) + req_nbytes) > NB;
    req_err      = req_illegal;
`else
    req_err      = req_illegal | req_misalign;
`endif
    be_full      = lsu_byte_en(lsu_size_e'(req_size), LSU_OFF_W'(req_off));
    req_be_win   = be_full[2*NB-1:0];
    req_din_win  = {{RAM_WIDTH{1'b0}}, req_wdata} << {req_off, 3'b000};
  end

  lsu_rdata_align #(
    .RAM_WIDTH(RAM_WIDTH)
  ) u_align (
    .win        (cap_win),
    .off        (off_q),
    .size       (size_q),
    .is_unsigned(uns_q),
    .rdata      (align_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      ram_addr    <= '0;
      ram_din     <= '0;
      ram_we      <= 1'b0;
      ram_byte_en <= '0;
      we_q        <= 1'b0;
      size_q      <= SZ_B;
      uns_q       <= 1'b0;
      off_q       <= '0;
      wa_q        <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q     <= 1'b0;
      be_hi_q     <= '0;
      din_hi_q    <= '0;
      lo_q        <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            size_q    <= lsu_size_e'(req_size);
            uns_q     <= req_unsigned;
            off_q     <= req_off;
            wa_q      <= req_wa;
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state       <= ISSUE0;
              ram_addr    <= req_wa;
              ram_din     <= req_din_win[RAM_WIDTH-1:0];
              ram_byte_en <= req_be_win[NB-1:0];
              ram_we      <= req_we;
`ifdef LSU_MISALIGN_SPLIT_EN
              split_q     <= req_split;
              be_hi_q     <= req_be_win[2*NB-1:NB];
              din_hi_q    <= req_din_win[2*RAM_WIDTH-1:RAM_WIDTH];
`endif
            end
          end
        end
        ISSUE0: begin
`ifdef LSU_MISALIGN_SPLIT_EN
          if (split_q) begin
            state       <= ISSUE1;
            ram_addr    <= wa_next;
            ram_din     <= din_hi_q;
            ram_byte_en <= be_hi_q;
            ram_we      <= we_q;
          end else
`endif
          begin
            ram_we      <= 1'b0;
            ram_byte_en <= '0;
            if (we_q) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= '0;
            end else begin
              state <= CAPTURE;
            end
          end
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        ISSUE1: begin
          lo_q        <= ram_dout;
          ram_we      <= 1'b0;
          ram_byte_en <= '0;
          if (we_q) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
          end else begin
            state <= CAPTURE;
          end
        end
`endif
        CAPTURE: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= align_rdata;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          req_ready   <= 1'b1;
          ram_we      <= 1'b0;
          ram_byte_en <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_load_store_unit.sv
// Self-checking bench for ram_load_store_unit: directed vector table, corner sequences,
// and randomized traffic checked against a byte-array memory model.
module tb_ram_load_store_unit;

  localparam int unsigned W = 32;
  localparam int unsigned DEPTH = 512;
  localparam int unsigned NBYTES = DEPTH * 4;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [10:0] req_addr;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [8:0]  ram_addr;
  logic [31:0] ram_din;
  logic        ram_we;
  logic [3:0]  ram_byte_en;
  logic [31:0] ram_dout;

  int n_tests = 0;
  int n_fail  = 0;

  ram_load_store_unit #(
    .RAM_WIDTH(W),
    .RAM_DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .ram_we      (ram_we),
    .ram_byte_en (ram_byte_en),
    .ram_dout    (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-enabled RAM with registered read.
  logic [31:0] tb_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_byte_en[b]) tb_mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      end
    end
    ram_dout <= tb_mem[ram_addr];
  end

  // Write beats seen on the RAM port.
  logic [8:0]  wr_addr_q [$];
  logic [3:0]  wr_be_q [$];
  logic [31:0] wr_din_q [$];
  always @(posedge clk) begin
    if (ram_we) begin
      wr_addr_q.push_back(ram_addr);
      wr_be_q.push_back(ram_byte_en);
      wr_din_q.push_back(ram_din);
    end
  end

  // Reference memory as a flat byte array.
  logic [7:0] ref_mem [NBYTES];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [10:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic err, output int lat,
                       output int beats);
    int  n, a, off;
    logic mis, split;
    n     = 1 << size;
    a     = int'(addr);
    off   = a % 4;
    mis   = (a % n) != 0;
    split = (off + n) > 4;
`ifdef LSU_MISALIGN_SPLIT_EN
    err = (n > 4);
`else
    err = (n > 4) || mis;
`endif
    rd    = '0;
    beats = 0;
    if (err) begin
      lat = 1;
    end else if (we) begin
      for (int k = 0; k < n; k++) ref_mem[(a + k) % NBYTES] = wdata[8*k +: 8];
      beats = split ? 2 : 1;
      lat   = split ? 3 : 2;
    end else begin
      for (int k = 0; k < n; k++) rd[8*k +: 8] = ref_mem[(a + k) % NBYTES];
      if (!uns && rd[8*n-1]) begin
        for (int k = n; k < 4; k++) rd[8*k +: 8] = 8'hFF;
      end
      lat = split ? 4 : 3;
    end
  endtask

  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [10:0] addr, input logic [31:0] wdata, input int hold,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int beats);
    int   guard;
    logic stable;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!req_ready) check("req_ready_timeout", 64'(req_ready), 64'd1);
    wr_addr_q.delete();
    wr_be_q.delete();
    wr_din_q.delete();
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid) check("resp_valid_timeout", 64'(resp_valid), 64'd1);
    rdata = resp_rdata;
    err   = resp_err;
    if (hold > 0) begin
      stable = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        if (resp_valid !== 1'b1 || resp_rdata !== rdata || resp_err !== err ||
            req_ready !== 1'b0) stable = 1'b0;
      end
      check("resp_hold_stable", 64'(stable), 64'd1);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    beats = wr_addr_q.size();
    check("idle_after_resp", {62'd0, req_ready, resp_valid}, 64'b10);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_beats;
    logic [8:0]  exp_wa0;
    logic [3:0]  exp_be0;
    logic [31:0] exp_din0;
    logic [8:0]  exp_wa1;
    logic [3:0]  exp_be1;
  } vec_t;

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
    return m;
  endfunction

  initial begin
    vec_t        vecs [$];
    logic [31:0] rd, m_rd;
    logic        er, m_er;
    int          lat, beats, m_lat, m_beats;
    logic        we;
    logic [1:0]  sz;
    logic        un;
    logic [10:0] ad;
    logic [31:0] wd;

    for (int i = 0; i < int'(DEPTH); i++) tb_mem[i] = '0;
    for (int i = 0; i < int'(NBYTES); i++) ref_mem[i] = '0;
    req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
    req_addr = '0; req_wdata = '0; resp_ready = 0;
    reset = 1'b1;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_ram_we", 64'(ram_we), 64'd0);
    check("rst_ram_byte_en", 64'(ram_byte_en), 64'd0);
    check("rst_ram_addr", 64'(ram_addr), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    //           we    sz    un    addr      wdata         rdata         err lat bt wa0  be0   din0          wa1  be1
    vecs.push_back('{1'b1, 2'd2, 1'b0, 11'h010, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 9'd4, 4'hF, 32'hDEADBEEF, 9'd0, 4'h0});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 11'h010, 32'h0,        32'hDEADBEEF, 1'b0, 3, 0, 9'd0, 4'h0, 32'h0,        9'd0, 4'h0});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 11'h010, 32'h0,        32'hFFFFFFEF, 1'b0, 3, 0, 9'd0, 4'h0, 32'h0,        9'd0, 4'h0});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 11'h012, 32'h0,        32'h0000DEAD, 1'b0, 3, 0, 9'd0, 4'h0, 32'h0,        9'd0, 4'h0});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 11'h013, 32'h12345680, 32'h0,        1'b0, 2, 1, 9'd4, 4'h8, 32'h80000000, 9'd0, 4'h0});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 11'h013, 32'h0,        32'hFFFFFF80, 1'b0, 3, 0, 9'd0, 4'h0, 32'h0,        9'd0, 4'h0});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 11'h013, 32'h0,        32'h00000080, 1'b0, 3, 0, 9'd0, 4'h0, 32'h0,        9'd0, 4'h0});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 11'h010, 32'h0,        32'h80ADBEEF, 1'b0, 3, 0, 9'd0, 4'h0, 32'h0,        9'd0, 4'h0});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 11'h00E, 32'h0000A5C3, 32'h0,        1'b0, 2, 1, 9'd3, 4'hC, 32'hA5C30000, 9'd0, 4'h0});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 11'h00E, 32'h0,        32'hFFFFA5C3, 1'b0, 3, 0, 9'd0, 4'h0, 32'h0,        9'd0, 4'h0});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 11'h00E, 32'h0,        32'h0000A5C3, 1'b0, 3, 0, 9'd0, 4'h0, 32'h0,        9'd0, 4'h0});
    vecs.push_back('{1'b0, 2'd3, 1'b0, 11'h008, 32'h0,        32'h0,        1'b1, 1, 0, 9'd0, 4'h0, 32'h0,        9'd0, 4'h0});
    vecs.push_back('{1'b1, 2'd3, 1'b0, 11'h008, 32'h55AA55AA, 32'h0,        1'b1, 1, 0, 9'd0, 4'h0, 32'h0,        9'd0, 4'h0});
`ifdef LSU_MISALIGN_SPLIT_EN
    vecs.push_back('{1'b1, 2'd2, 1'b0, 11'h7FF, 32'h11223344, 32'h0,        1'b0, 3, 2, 9'd511, 4'h8, 32'h44000000, 9'd0, 4'h7});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 11'h7FF, 32'h0,        32'h11223344, 1'b0, 4, 0, 9'd0, 4'h0, 32'h0,        9'd0, 4'h0});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 11'h011, 32'h0,        32'hFFFFADBE, 1'b0, 3, 0, 9'd0, 4'h0, 32'h0,        9'd0, 4'h0});
`else
    vecs.push_back('{1'b0, 2'd2, 1'b0, 11'h005, 32'h0,        32'h0,        1'b1, 1, 0, 9'd0, 4'h0, 32'h0,        9'd0, 4'h0});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 11'h001, 32'hFFFF,     32'h0,        1'b1, 1, 0, 9'd0, 4'h0, 32'h0,        9'd0, 4'h0});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 11'h7FF, 32'h11223344, 32'h0,        1'b1, 1, 0, 9'd0, 4'h0, 32'h0,        9'd0, 4'h0});
`endif

    foreach (vecs[i]) begin
      run_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, 0,
              rd, er, lat, beats);
      model(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
            m_rd, m_er, m_lat, m_beats);
      check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
      check($sformatf("vec%0d_err", i), 64'(er), 64'(vecs[i].exp_err));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      check($sformatf("vec%0d_write_beats", i), 64'(beats), 64'(vecs[i].exp_beats));
      if (vecs[i].exp_beats > 0 && beats > 0) begin
        check($sformatf("vec%0d_wa0", i), 64'(wr_addr_q[0]), 64'(vecs[i].exp_wa0));
        check($sformatf("vec%0d_be0", i), 64'(wr_be_q[0]), 64'(vecs[i].exp_be0));
        check($sformatf("vec%0d_din0", i), 64'(wr_din_q[0] & lane_mask(wr_be_q[0])),
              64'(vecs[i].exp_din0));
      end
      if (vecs[i].exp_beats > 1 && beats > 1) begin
        check($sformatf("vec%0d_wa1", i), 64'(wr_addr_q[1]), 64'(vecs[i].exp_wa1));
        check($sformatf("vec%0d_be1", i), 64'(wr_be_q[1]), 64'(vecs[i].exp_be1));
      end
    end

    // Response held for five cycles with resp_ready low.
    run_req(1'b0, 2'd2, 1'b0, 11'h010, 32'h0, 5, rd, er, lat, beats);
    check("hold_rdata", 64'(rd), 64'h80ADBEEF);

    // Reset while the store beat is on the RAM port.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 11'h020; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("issue0_ram_we", 64'(ram_we), 64'd1);
    reset = 1'b1;
    #1;
    check("midop_rst_ram_we", 64'(ram_we), 64'd0);
    check("midop_rst_req_ready", 64'(req_ready), 64'd1);
    check("midop_rst_resp_valid", 64'(resp_valid), 64'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    run_req(1'b0, 2'd2, 1'b0, 11'h020, 32'h0, 0, rd, er, lat, beats);
    check("aborted_store_absent", 64'(rd), 64'd0);

    // Randomized traffic against the byte-array model.
    for (int t = 0; t < 300; t++) begin
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      un = 1'($urandom_range(0, 1));
      ad = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(2032, 2047))
                                       : 11'($urandom_range(0, 63));
      wd = $urandom;
      model(we, sz, un, ad, wd, m_rd, m_er, m_lat, m_beats);
      run_req(we, sz, un, ad, wd, int'($urandom_range(0, 2)), rd, er, lat, beats);
      check($sformatf("rnd%0d_rdata", t), 64'(rd), 64'(m_rd));
      check($sformatf("rnd%0d_err", t), 64'(er), 64'(m_er));
      check($sformatf("rnd%0d_latency", t), 64'(lat), 64'(m_lat));
      check($sformatf("rnd%0d_write_beats", t), 64'(beats), 64'(m_beats));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
